// File: rtl/eoc_pkg.sv
// Shared definitions for the end-of-computation monitor: FSM state
// encoding, exit-status codes and channel-count limits.
package eoc_pkg;

   // Largest number of cores/threads a single monitor is meant to watch.
   localparam int EOC_MAX_CH = 8;

   // Monitor FSM states.
   typedef enum logic [1:0] {
      EOC_IDLE   = 2'b00,
      EOC_RUN    = 2'b01,
      EOC_FINISH = 2'b10
   } eoc_state_e;

   // Exit status as reported to the test harness (exit codes 0 / 1 / -1).
   localparam logic [1:0] EXIT_SUCCESS = 2'b00;
   localparam logic [1:0] EXIT_FAIL    = 2'b01;
   localparam logic [1:0] EXIT_ERROR   = 2'b11;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int fail_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/eoc_channel.sv
// One monitored channel: sticky done latch, return-code register and
// code-seen flag. The next-state values are exported so the top level
// can judge the final status in the same cycle the last done arrives.
module eoc_channel
   import eoc_pkg::*;
#(
   parameter int CODE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              run,
   input  logic              done_i,
   input  logic              code_valid_i,
   input  logic [CODE_W-1:0] code_i,
   output logic              done_q,
   output logic              done_nxt,
   output logic              seen_nxt,
   output logic [CODE_W-1:0] code_nxt
);

   logic              seen_q;
   logic [CODE_W-1:0] code_q;

   // Codes are accepted only until the channel reports done, so a strobe in
   // the same cycle as done still counts but anything later is ignored.
   always_comb begin
      done_nxt = done_q;
      seen_nxt = seen_q;
      code_nxt = code_q;
      if (clear) begin
         done_nxt = 1'b0;
         seen_nxt = 1'b0;
         code_nxt = '0;
      end else if (run) begin
         if (code_valid_i && !done_q) begin
            code_nxt = code_i;
            seen_nxt = 1'b1;
         end
         if (done_i) begin
            done_nxt = 1'b1;
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
         seen_q <= 1'b0;
         code_q <= '0;
      end else begin
         done_q <= done_nxt;
         seen_q <= seen_nxt;
         code_q <= code_nxt;
      end
   end

endmodule

// File: rtl/eoc_monitor.sv
// End-of-computation monitor: arms on a start pulse, counts run cycles,
// collects per-channel done flags and return codes, and reports a final
// exit status when all channels are done or the watchdog expires.
module eoc_monitor
   import eoc_pkg::*;
#(
   parameter int NUM_CH = 1,
   parameter int CODE_W = 8,
   parameter int CNT_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_i,
   input  logic [CNT_W-1:0]           timeout_i,
   input  logic [NUM_CH-1:0]          done_i,
   input  logic [NUM_CH-1:0]          code_valid_i,
   input  logic [NUM_CH*CODE_W-1:0]   code_i,
   output logic                       busy_o,
   output logic                       finished_o,
   output logic [1:0]                 exit_status_o,
   output logic                       timed_out_o,
   output logic [NUM_CH-1:0]          done_mask_o,
   output logic [fail_w(NUM_CH)-1:0]  fail_ch_o,
   output logic [CNT_W-1:0]           cycles_o
);

   localparam int FAIL_W = fail_w(NUM_CH);

   localparam logic [1:0] ST_IDLE   = EOC_IDLE;
   localparam logic [1:0] ST_RUN    = EOC_RUN;
   localparam logic [1:0] ST_FINISH = EOC_FINISH;

   logic [1:0]                     state_q;
   logic                           run;
   logic                           clear;
   logic [NUM_CH-1:0]              done_q;
   logic [NUM_CH-1:0]              done_nxt;
   logic [NUM_CH-1:0]              seen_nxt;
   logic [NUM_CH-1:0][CODE_W-1:0]  code_nxt;
   logic [NUM_CH-1:0]              nonzero;
   logic [NUM_CH-1:0]              bad;
   logic [FAIL_W-1:0]              fail_nxt;
   logic [1:0]                     status_nxt;
   logic [CNT_W-1:0]               cyc_inc;
   logic                           all_done;
   logic                           expire;

   assign run   = (state_q == ST_RUN);
   assign clear = start_i && (state_q != ST_RUN);

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      eoc_channel #(
         .CODE_W(CODE_W)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .clear       (clear),
         .run         (run),
         .done_i      (done_i[k]),
         .code_valid_i(code_valid_i[k]),
         .code_i      (code_i[k*CODE_W +: CODE_W]),
         .done_q      (done_q[k]),
         .done_nxt    (done_nxt[k]),
         .seen_nxt    (seen_nxt[k]),
         .code_nxt    (code_nxt[k])
      );
   end

   // Classify each channel by the values it will hold after this edge, so a
   // code captured together with the final done is already accounted for.
   always_comb begin
      nonzero = '0;
      bad     = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         nonzero[k] = (code_nxt[k] != '0);
         bad[k]     = !seen_nxt[k] || nonzero[k];
      end
   end

   // Lowest-index channel that failed or never delivered a code.
   always_comb begin
      fail_nxt = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (bad[k]) begin
            fail_nxt = FAIL_W'(k);
         end
      end
   end

   // Completion status; a missing code outranks a nonzero one.
   always_comb begin
      status_nxt = EXIT_SUCCESS;
      if (!(&seen_nxt)) begin
         status_nxt = EXIT_ERROR;
      end else if (|nonzero) begin
         status_nxt = EXIT_FAIL;
      end
   end

   // The watchdog fires in the run cycle that brings the count up to the
   // limit, so FINISH follows exactly timeout_i run cycles.
   assign cyc_inc  = cycles_o + CNT_W'(1);
   assign all_done = &done_nxt;
   assign expire   = run && (timeout_i != '0) && (cyc_inc == timeout_i);

   // Main FSM plus the cycle counter and the reported result registers;
   // completion is tested before the watchdog so a tie counts as success.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         exit_status_o <= EXIT_ERROR;
         timed_out_o   <= 1'b0;
         fail_ch_o     <= '0;
         cycles_o      <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_FINISH: begin
               if (start_i) begin
                  state_q     <= ST_RUN;
                  cycles_o    <= '0;
                  timed_out_o <= 1'b0;
               end
            end
            ST_RUN: begin
               if (cycles_o != '1) begin
                  cycles_o <= cyc_inc;
               end
               if (all_done) begin
                  state_q       <= ST_FINISH;
                  exit_status_o <= status_nxt;
                  fail_ch_o     <= fail_nxt;
               end else if (expire) begin
                  state_q       <= ST_FINISH;
                  timed_out_o   <= 1'b1;
                  exit_status_o <= EXIT_ERROR;
                  fail_ch_o     <= fail_nxt;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o      = (state_q == ST_RUN);
   assign finished_o  = (state_q == ST_FINISH);
   assign done_mask_o = done_q;

endmodule

// File: tb/tb_eoc_monitor.sv
// Self-checking bench for eoc_monitor: a 4-channel instance exercised with
// directed and random run plans judged by a plan-level reference model,
// plus a single-channel instance for the basic success case.
module tb_eoc_monitor;

   localparam int NCH   = 4;
   localparam int CW    = 8;
   localparam int NEVER = 1000;
   localparam int MAXC  = 128;
   localparam int BUDGET = 200;

   logic              clk;
   logic              rst_n;

   logic              start;
   logic [31:0]       timeout;
   logic [NCH-1:0]    done;
   logic [NCH-1:0]    cv;
   logic [NCH*CW-1:0] code;
   logic              busy;
   logic              finished;
   logic [1:0]        status;
   logic              timed;
   logic [NCH-1:0]    mask;
   logic [1:0]        fail_ch;
   logic [31:0]       cycles;

   logic              start1;
   logic [31:0]       timeout1;
   logic [0:0]        done1;
   logic [0:0]        cv1;
   logic [CW-1:0]     code1;
   logic              busy1;
   logic              finished1;
   logic [1:0]        status1;
   logic              timed1;
   logic [0:0]        mask1;
   logic [0:0]        fail_ch1;
   logic [31:0]       cycles1;

   int vectors;
   int miscompares;

   // Run plan: done cycle per channel, code strobes per cycle, watchdog
   // limit and a cycle in which a stray start pulse is thrown in.
   int         d_plan [NCH];
   bit         sv     [NCH][MAXC];
   logic [7:0] sc     [NCH][MAXC];
   int         t_plan;
   int         ign_start;

   eoc_monitor #(.NUM_CH(NCH), .CODE_W(CW), .CNT_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .timeout_i    (timeout),
      .done_i       (done),
      .code_valid_i (cv),
      .code_i       (code),
      .busy_o       (busy),
      .finished_o   (finished),
      .exit_status_o(status),
      .timed_out_o  (timed),
      .done_mask_o  (mask),
      .fail_ch_o    (fail_ch),
      .cycles_o     (cycles)
   );

   eoc_monitor #(.NUM_CH(1), .CODE_W(CW), .CNT_W(32)) dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start1),
      .timeout_i    (timeout1),
      .done_i       (done1),
      .code_valid_i (cv1),
      .code_i       (code1),
      .busy_o       (busy1),
      .finished_o   (finished1),
      .exit_status_o(status1),
      .timed_out_o  (timed1),
      .done_mask_o  (mask1),
      .fail_ch_o    (fail_ch1),
      .cycles_o     (cycles1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearPlan();
      for (int k = 0; k < NCH; k++) begin
         d_plan[k] = NEVER;
         for (int c = 0; c < MAXC; c++) begin
            sv[k][c] = 1'b0;
            sc[k][c] = 8'h00;
         end
      end
      t_plan    = 0;
      ign_start = 0;
   endtask

   task automatic addStrobe(input int k, input int c, input logic [7:0] v);
      sv[k][c] = 1'b1;
      sc[k][c] = v;
   endtask

   // Reference model: works out from the plan alone how long the run lasts,
   // whether the watchdog wins, and what each channel ends up reporting.
   task automatic modelPlan(output int len, output bit tmo, output logic [1:0] st,
                            output logic [NCH-1:0] mk, output logic [1:0] fc);
      int         last_done;
      bit         all_fin;
      bit         missing;
      bit         nz;
      bit         found;
      int         lim;
      bit         seen;
      logic [7:0] val;
      last_done = 0;
      all_fin   = 1'b1;
      for (int k = 0; k < NCH; k++) begin
         if (d_plan[k] >= NEVER) all_fin = 1'b0;
         else if (d_plan[k] > last_done) last_done = d_plan[k];
      end
      if (all_fin && (t_plan == 0 || last_done <= t_plan)) begin
         len = last_done;
         tmo = 1'b0;
      end else begin
         len = t_plan;
         tmo = 1'b1;
      end
      missing = 1'b0;
      nz      = 1'b0;
      found   = 1'b0;
      fc      = 2'd0;
      for (int k = 0; k < NCH; k++) begin
         lim  = (d_plan[k] < len) ? d_plan[k] : len;
         seen = 1'b0;
         val  = 8'h00;
         for (int c = 1; c <= lim && c < MAXC; c++) begin
            if (sv[k][c]) begin
               seen = 1'b1;
               val  = sc[k][c];
            end
         end
         mk[k] = (d_plan[k] <= len);
         if (!seen) missing = 1'b1;
         if (val != 8'h00) nz = 1'b1;
         if (!found && (!seen || val != 8'h00)) begin
            found = 1'b1;
            fc    = 2'(k);
         end
      end
      st = (tmo || missing) ? 2'b11 : (nz ? 2'b01 : 2'b00);
   endtask

   // Drive the inputs that belong to run cycle c of the current plan.
   task automatic applyStimulus(input int c);
      for (int k = 0; k < NCH; k++) begin
         done[k] = (d_plan[k] < NEVER) && (c >= d_plan[k]);
         cv[k]   = 1'b0;
         code[k*CW +: CW] = 8'($urandom);
         if (c < MAXC) begin
            if (sv[k][c]) begin
               cv[k] = 1'b1;
               code[k*CW +: CW] = sc[k][c];
            end
         end
      end
      start = (c == ign_start);
   endtask

   task automatic idleInputs();
      start = 1'b0;
      done  = '0;
      cv    = '0;
      code  = '0;
   endtask

   task automatic runPlan(input string name);
      int              len;
      bit              tmo;
      logic [1:0]      st;
      logic [NCH-1:0]  mk;
      logic [1:0]      fc;
      int              fin;
      modelPlan(len, tmo, st, mk, fc);
      timeout = t_plan;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput({name, "/busy"}, {63'd0, busy}, 64'd1);
      fin = -1;
      for (int c = 1; c <= BUDGET && fin < 0; c++) begin
         applyStimulus(c);
         @(posedge clk);
         #1;
         if (finished) fin = c;
      end
      idleInputs();
      checkOutput({name, "/finish_cycle"}, 64'(fin), 64'(len));
      for (int r = 0; r < 4; r++) begin
         checkOutput({name, "/status"},  {62'd0, status},  {62'd0, st});
         checkOutput({name, "/timeout"}, {63'd0, timed},   {63'd0, tmo});
         checkOutput({name, "/mask"},    {60'd0, mask},    {60'd0, mk});
         checkOutput({name, "/fail_ch"}, {62'd0, fail_ch}, {62'd0, fc});
         checkOutput({name, "/cycles"},  {32'd0, cycles},  64'(len));
         checkOutput({name, "/flags"},   {62'd0, busy, finished}, 64'd1);
         done = NCH'($urandom);
         cv   = NCH'($urandom);
         code = 32'($urandom);
         @(posedge clk);
         #1;
      end
      idleInputs();
   endtask

   task automatic randomPlan();
      bit all_fin;
      int n;
      int c;
      clearPlan();
      all_fin = 1'b1;
      for (int k = 0; k < NCH; k++) begin
         if ($urandom_range(5) == 0) begin
            all_fin = 1'b0;
         end else begin
            d_plan[k] = $urandom_range(1, 40);
         end
         n = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) begin
            c = $urandom_range(1, 45);
            addStrobe(k, c, ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
         end
      end
      t_plan    = (all_fin && $urandom_range(2) == 0) ? 0 : $urandom_range(5, 60);
      ign_start = $urandom_range(1, 30);
   endtask

   task automatic checkReset(input string name);
      checkOutput({name, "/busy"},     {63'd0, busy},     64'd0);
      checkOutput({name, "/finished"}, {63'd0, finished}, 64'd0);
      checkOutput({name, "/status"},   {62'd0, status},   64'd3);
      checkOutput({name, "/timeout"},  {63'd0, timed},    64'd0);
      checkOutput({name, "/mask"},     {60'd0, mask},     64'd0);
      checkOutput({name, "/fail_ch"},  {62'd0, fail_ch},  64'd0);
      checkOutput({name, "/cycles"},   {32'd0, cycles},   64'd0);
   endtask

   initial begin
      int fin;
      vectors     = 0;
      miscompares = 0;
      rst_n    = 1'b0;
      timeout  = '0;
      idleInputs();
      start1   = 1'b0;
      timeout1 = '0;
      done1    = '0;
      cv1      = '0;
      code1    = '0;
      clearPlan();
      repeat (3) @(posedge clk);
      #1;
      checkReset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single channel: zero code at cycle 10, done at cycle 20; finished is
      // first seen after the 20th edge past start (i.e. during cycle 21).
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      fin = -1;
      for (int c = 1; c <= 60 && fin < 0; c++) begin
         cv1   = (c == 10);
         code1 = (c == 10) ? 8'h00 : 8'($urandom);
         done1 = (c >= 20);
         @(posedge clk);
         #1;
         if (finished1) fin = c;
      end
      cv1   = '0;
      done1 = '0;
      checkOutput("ch1/finish_cycle", 64'(fin), 64'd20);
      checkOutput("ch1/status",  {62'd0, status1},  64'd0);
      checkOutput("ch1/cycles",  {32'd0, cycles1},  64'd20);
      checkOutput("ch1/fail_ch", {63'd0, fail_ch1}, 64'd0);
      checkOutput("ch1/mask",    {63'd0, mask1},    64'd1);
      checkOutput("ch1/timeout", {63'd0, timed1},   64'd0);

      // Codes 0,0,5,7 with staggered dones.
      clearPlan();
      d_plan[0] = 10; d_plan[1] = 15; d_plan[2] = 20; d_plan[3] = 25;
      addStrobe(0, 5, 8'h00);
      addStrobe(1, 3, 8'h00);
      addStrobe(2, 8, 8'h05);
      addStrobe(3, 12, 8'h07);
      runPlan("stagger");

      // Watchdog at 100 with no done at all.
      clearPlan();
      t_plan = 100;
      runPlan("watchdog");

      // Last done lands exactly on the expiry cycle, code strobed with it.
      clearPlan();
      t_plan = 50;
      d_plan[0] = 10; d_plan[1] = 20; d_plan[2] = 30; d_plan[3] = 50;
      for (int k = 0; k < NCH; k++) addStrobe(k, 5, 8'h00);
      addStrobe(3, 50, 8'h33);
      runPlan("tie");

      // Channel 1 never strobes; channel 0 strobes again after its done.
      clearPlan();
      d_plan[0] = 10; d_plan[1] = 12; d_plan[2] = 14; d_plan[3] = 16;
      addStrobe(0, 4, 8'h00);
      addStrobe(0, 15, 8'h44);
      addStrobe(2, 2, 8'h00);
      addStrobe(3, 2, 8'h00);
      runPlan("missing");

      // Reset in the middle of a run, then a fresh run.
      clearPlan();
      timeout = '0;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         applyStimulus(c);
         @(posedge clk);
         #1;
      end
      #3;
      rst_n = 1'b0;
      #1;
      checkReset("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      idleInputs();
      repeat (5) @(posedge clk);
      #1;
      checkOutput("midreset/idle", {62'd0, busy, finished}, 64'd0);
      clearPlan();
      d_plan[0] = 7; d_plan[1] = 3; d_plan[2] = 9; d_plan[3] = 4;
      for (int k = 0; k < NCH; k++) addStrobe(k, 2, 8'h00);
      runPlan("after_reset");

      for (int i = 0; i < 25; i++) begin
         randomPlan();
         runPlan($sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
